// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Function : Receives a length-prefixed, XOR-checksummed byte stream and writes
//            it into instruction memory as big-endian words, holding the CPU in
//            reset until a load completes with a good checksum.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clock,
  input  logic        start,
  input  logic        load_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_start,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len_hi;
  logic [15:0] r_len;
  logic [15:0] r_index;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic [7:0]  r_chk;
  logic        w_accept;
  logic [15:0] w_len_new;
  logic        w_last_byte;

  assign w_accept    = byte_valid && byte_ready;
  assign w_len_new   = {r_len_hi, byte_data};
  assign w_last_byte = (r_byte_cnt == 2'd3) && (r_index == r_len - 16'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (load_req) w_next = S_LEN_HI;
      S_LEN_HI: if (w_accept) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_new == 16'd0)
            w_next = S_CHECK;
          else if ({16'd0, w_len_new} > 32'(MAX_WORDS))
            w_next = S_ERR;
          else
            w_next = S_DATA;
        end
      end
      S_DATA:  if (w_accept && w_last_byte) w_next = S_CHECK;
      S_CHECK: if (w_accept) w_next = (byte_data == r_chk) ? S_DONE : S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      r_state    <= S_IDLE;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
      cpu_start  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      r_len_hi   <= 8'd0;
      r_len      <= 16'd0;
      r_index    <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_word     <= 24'd0;
      r_chk      <= 8'd0;
    end else begin
      r_state    <= w_next;
      byte_ready <= (w_next == S_LEN_HI) || (w_next == S_LEN_LO) ||
                    (w_next == S_DATA)   || (w_next == S_CHECK);
      done       <= (w_next == S_DONE);
      error      <= (w_next == S_ERR);
      cpu_start  <= (w_next != S_DONE);
      imem_we    <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (load_req) begin
            r_chk      <= 8'd0;
            r_index    <= 16'd0;
            r_byte_cnt <= 2'd0;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len_hi <= byte_data;
            r_chk    <= r_chk ^ byte_data;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len_new;
            r_chk <= r_chk ^ byte_data;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_chk      <= r_chk ^ byte_data;
            r_word     <= {r_word[15:0], byte_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Address wraps naturally in 32 bits.
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR + {14'd0, r_index, 2'b00};
              imem_wdata <= {r_word, byte_data};
              r_index    <= r_index + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Function : Directed bench for imem_loader with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clock = 1'b0;
  logic        start = 1'b1;
  logic        load_req = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_start;
  logic        done;
  logic        error;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .start(start), .load_req(load_req),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] hold_addr = BASE;
  logic [31:0] hold_data = 32'd0;
  logic [31:0] exp_a, exp_d;
  int          seen_writes = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_data = 32'd0;
  logic [7:0]  frame[$];
  logic [7:0]  model_chk;
  int          sw;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Every write must match the next model write; between writes addr/data hold.
  always @(negedge clock) begin
    if (start) begin
      hold_addr = BASE;
      hold_data = 32'd0;
    end else if (imem_we) begin
      if (exp_addr_q.size() == 0) begin
        check1("unexpected_write", imem_we, 1'b0);
        hold_addr = imem_addr;
        hold_data = imem_wdata;
      end else begin
        exp_a = exp_addr_q.pop_front();
        exp_d = exp_data_q.pop_front();
        check32("write_addr", imem_addr, exp_a);
        check32("write_data", imem_wdata, exp_d);
        hold_addr = exp_a;
        hold_data = exp_d;
      end
      seen_writes++;
      last_addr = imem_addr;
      last_data = imem_wdata;
    end else begin
      check32("addr_hold", imem_addr, hold_addr);
      check32("data_hold", imem_wdata, hold_data);
    end
  end

  task automatic pulse_req();
    @(negedge clock);
    byte_valid = 1'b0;
    load_req   = 1'b1;
    @(negedge clock);
    load_req   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit req_noise);
    int guard;
    for (int i = 0; i < gap; i++) begin
      @(negedge clock);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      load_req   = req_noise && (i == 0);
    end
    @(negedge clock);
    load_req   = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (!byte_ready && guard < 16) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 16) check1("byte_accept_timeout", byte_ready, 1'b1);
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  // Frame-level model: derives writes and outcome straight from the byte list.
  task automatic run_frame(input string tag, input bit noisy);
    int   len, consumed;
    logic [7:0] c;
    bit   ok;
    len = int'({frame[0], frame[1]});
    c   = frame[0] ^ frame[1];
    if (len > MAXW) begin
      consumed = 2;
      ok = 1'b0;
    end else begin
      for (int w = 0; w < len; w++) begin
        exp_addr_q.push_back(BASE + 32'(4 * w));
        exp_data_q.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
        for (int k = 0; k < 4; k++) c = c ^ frame[2+4*w+k];
      end
      consumed = 3 + 4 * len;
      ok = (frame[consumed-1] == c);
    end
    model_chk = c;
    pulse_req();
    for (int i = 0; i < consumed; i++)
      send_byte(frame[i], noisy ? int'($urandom_range(0, 3)) : 0, noisy);
    repeat (2) @(negedge clock);
    check1({tag, "_done"}, done, ok);
    check1({tag, "_error"}, error, !ok);
    check1({tag, "_cpu_start"}, cpu_start, !ok);
    check1({tag, "_byte_ready"}, byte_ready, 1'b0);
    check32({tag, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #12;
    check1("rst_byte_ready", byte_ready, 1'b0);
    check1("rst_imem_we", imem_we, 1'b0);
    check32("rst_addr", imem_addr, BASE);
    check32("rst_wdata", imem_wdata, 32'd0);
    check1("rst_cpu_start", cpu_start, 1'b1);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
    @(negedge clock);
    #3 start = 1'b0;

    // Good single-word load, pinned by literals.
    sw = seen_writes;
    frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
    run_frame("good", 1'b0);
    check32("good_write_count", 32'(seen_writes - sw), 32'd1);
    check32("good_addr_literal", last_addr, 32'h0000_0000);
    check32("good_wdata_literal", last_data, 32'h2008_0005);
    check32("model_chk_literal", 32'(model_chk), 32'h0000_002C);

    // Bad checksum: the write still happens.
    sw = seen_writes;
    frame = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
    run_frame("badchk", 1'b0);
    check32("badchk_write_count", 32'(seen_writes - sw), 32'd1);
    check1("badchk_error_literal", error, 1'b1);

    // Oversize length aborts right after LEN_LO.
    sw = seen_writes;
    frame = '{8'h04, 8'h01};
    run_frame("oversize", 1'b0);
    check32("oversize_write_count", 32'(seen_writes - sw), 32'd0);

    // Largest legal length is accepted into DATA (not ERR).
    pulse_req();
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    @(negedge clock);
    check1("maxlen_ready", byte_ready, 1'b1);
    check1("maxlen_error", error, 1'b0);
    @(negedge clock);
    #3 start = 1'b1;
    @(negedge clock);
    #3 start = 1'b0;

    // Zero length, good and bad trailer.
    frame = '{8'h00, 8'h00, 8'h00};
    run_frame("zero_good", 1'b0);
    frame = '{8'h00, 8'h00, 8'h01};
    run_frame("zero_bad", 1'b0);

    // Three words with gaps and stray load_req pulses.
    frame = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
              8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hCF};
    run_frame("gaps", 1'b1);
    check32("gaps_last_addr", last_addr, 32'h0000_0008);
    check32("gaps_last_data", last_data, 32'h99AA_BBCC);

    // Reset in the middle of a frame.
    sw = seen_writes;
    pulse_req();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    @(negedge clock);
    #3 start = 1'b1;
    #1;
    check1("midrst_byte_ready", byte_ready, 1'b0);
    check1("midrst_cpu_start", cpu_start, 1'b1);
    check1("midrst_imem_we", imem_we, 1'b0);
    check32("midrst_addr", imem_addr, BASE);
    @(negedge clock);
    #3 start = 1'b0;
    repeat (3) @(negedge clock);
    check1("midrst_idle_ready", byte_ready, 1'b0);
    check32("midrst_no_write", 32'(seen_writes - sw), 32'd0);

    frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
    run_frame("after_rst", 1'b0);
    check32("after_rst_last_addr", last_addr, 32'h0000_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
